// File: rtl/seq_alu_pkg.sv
// Shared opcode constants, FSM state type and small helpers for seq_alu.
package seq_alu_pkg;

   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_SUB = 4'b0001;
   localparam logic [3:0] OP_MUL = 4'b0010;
   localparam logic [3:0] OP_DIV = 4'b0011;
   localparam logic [3:0] OP_AND = 4'b1000;
   localparam logic [3:0] OP_OR  = 4'b1001;
   localparam logic [3:0] OP_XOR = 4'b1010;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   // True when the opcode needs the iterative unit (MUL, or DIV with a non-zero divisor).
   function automatic logic needs_iter(input logic [3:0] op, input logic divisor_zero);
      logic iter;
      iter = 1'b0;
      case (op)
         OP_MUL:  iter = 1'b1;
         OP_DIV:  iter = ~divisor_zero;
         default: iter = 1'b0;
      endcase
      return iter;
   endfunction

endpackage

// File: rtl/seq_alu_muldiv.sv
// Iterative unsigned multiply (shift-add) and divide (restoring), one bit per cycle.
// res_lo/res_hi present the register contents after the step being taken this cycle,
// so the caller can capture the final result on the same edge that done is high.
module seq_alu_muldiv
   import seq_alu_pkg::*;
#(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             is_div,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             done,
   output logic [WIDTH-1:0] res_lo,
   output logic [WIDTH-1:0] res_hi
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

   logic             busy_r;
   logic             is_div_r;
   logic [CNT_W-1:0] cnt_r;
   logic [WIDTH-1:0] hi_r;
   logic [WIDTH-1:0] lo_r;
   logic [WIDTH-1:0] opnd_r;

   logic [WIDTH:0]   mul_sum_s;
   logic [WIDTH:0]   div_sh_s;
   logic [WIDTH:0]   div_diff_s;
   logic [WIDTH-1:0] hi_nxt_s;
   logic [WIDTH-1:0] lo_nxt_s;
   logic             done_s;

   // One step of the datapath: shift-add for MUL, shift-and-trial-subtract for DIV.
   always_comb begin
      mul_sum_s  = {1'b0, hi_r} + {1'b0, opnd_r};
      div_sh_s   = {hi_r, lo_r[WIDTH-1]};
      div_diff_s = div_sh_s - {1'b0, opnd_r};
      hi_nxt_s   = hi_r;
      lo_nxt_s   = lo_r;
      if (is_div_r) begin
         // A clear top bit means the shifted remainder was >= divisor.
         if (!div_diff_s[WIDTH]) begin
            hi_nxt_s = div_diff_s[WIDTH-1:0];
            lo_nxt_s = {lo_r[WIDTH-2:0], 1'b1};
         end else begin
            hi_nxt_s = div_sh_s[WIDTH-1:0];
            lo_nxt_s = {lo_r[WIDTH-2:0], 1'b0};
         end
      end else begin
         // Multiplier sits in lo_r and is consumed LSB first as the product shifts in.
         if (lo_r[0]) begin
            {hi_nxt_s, lo_nxt_s} = {mul_sum_s, lo_r[WIDTH-1:1]};
         end else begin
            {hi_nxt_s, lo_nxt_s} = {1'b0, hi_r, lo_r[WIDTH-1:1]};
         end
      end
   end

   // Last step is the one taken while the counter reads WIDTH-1.
   always_comb begin
      done_s = busy_r & (cnt_r == LAST_STEP);
   end

   assign done   = done_s;
   assign res_lo = lo_nxt_s;
   assign res_hi = hi_nxt_s;

   // Load operands on start, then advance one step per cycle until the last step.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_r   <= 1'b0;
         is_div_r <= 1'b0;
         cnt_r    <= {CNT_W{1'b0}};
         hi_r     <= {WIDTH{1'b0}};
         lo_r     <= {WIDTH{1'b0}};
         opnd_r   <= {WIDTH{1'b0}};
      end else if (start) begin
         busy_r   <= 1'b1;
         is_div_r <= is_div;
         cnt_r    <= {CNT_W{1'b0}};
         hi_r     <= {WIDTH{1'b0}};
         lo_r     <= is_div ? op_a : op_b;
         opnd_r   <= is_div ? op_b : op_a;
      end else if (busy_r) begin
         hi_r <= hi_nxt_s;
         lo_r <= lo_nxt_s;
         if (done_s) begin
            busy_r <= 1'b0;
            cnt_r  <= {CNT_W{1'b0}};
         end else begin
            cnt_r  <= cnt_r + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/seq_alu.sv
// Handshaked sequential ALU: single-cycle add/sub/logic, iterative mul/div.
// Holds one operation at a time; in_ready stays low until the result is taken.
module seq_alu
   import seq_alu_pkg::*;
#(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       operation,
   input  logic [WIDTH-1:0] firstInput,
   input  logic [WIDTH-1:0] secondInput,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] ALU_Out,
   output logic [WIDTH-1:0] ALU_OutHi,
   output logic             CarryOut,
   output logic             ZeroOut,
   output logic             DivByZero
);

   state_t           state_r;
   state_t           state_nxt_s;
   logic             ready_r;
   logic             out_valid_r;
   logic [WIDTH-1:0] lo_r;
   logic [WIDTH-1:0] hi_r;
   logic             carry_r;
   logic             zero_r;
   logic             dbz_r;

   logic             accept_s;
   logic             iter_s;
   logic             start_s;
   logic             load_single_s;
   logic             load_iter_s;

   logic [WIDTH:0]   sum_s;
   logic [WIDTH:0]   diff_s;
   logic [WIDTH-1:0] sc_lo_s;
   logic [WIDTH-1:0] sc_hi_s;
   logic             sc_carry_s;
   logic             sc_dbz_s;

   logic             md_done_s;
   logic [WIDTH-1:0] md_lo_s;
   logic [WIDTH-1:0] md_hi_s;

   // Single-cycle datapath, evaluated on the operands presented at acceptance.
   always_comb begin
      sum_s      = {1'b0, firstInput} + {1'b0, secondInput};
      diff_s     = {1'b0, firstInput} - {1'b0, secondInput};
      sc_lo_s    = sum_s[WIDTH-1:0];
      sc_hi_s    = {WIDTH{1'b0}};
      sc_carry_s = 1'b0;
      sc_dbz_s   = 1'b0;
      case (operation)
         OP_ADD: begin
            sc_lo_s    = sum_s[WIDTH-1:0];
            sc_carry_s = sum_s[WIDTH];
         end
         OP_SUB: begin
            sc_lo_s    = diff_s[WIDTH-1:0];
            sc_carry_s = ~diff_s[WIDTH];
         end
         OP_DIV: begin
            // Only reaches the output registers when the divisor is zero.
            sc_lo_s  = {WIDTH{1'b1}};
            sc_hi_s  = firstInput;
            sc_dbz_s = 1'b1;
         end
         OP_AND: sc_lo_s = firstInput & secondInput;
         OP_OR:  sc_lo_s = firstInput | secondInput;
         OP_XOR: sc_lo_s = firstInput ^ secondInput;
         default: begin
            // Unlisted opcodes (MUL never lands here as a single-cycle op) behave as ADD.
            sc_lo_s    = sum_s[WIDTH-1:0];
            sc_carry_s = sum_s[WIDTH];
         end
      endcase
   end

   // Handshake FSM next-state and strobes.
   always_comb begin
      state_nxt_s   = state_r;
      accept_s      = in_valid & ready_r;
      iter_s        = needs_iter(operation, secondInput == {WIDTH{1'b0}});
      start_s       = 1'b0;
      load_single_s = 1'b0;
      load_iter_s   = 1'b0;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               if (iter_s) begin
                  start_s     = 1'b1;
                  state_nxt_s = BUSY;
               end else begin
                  load_single_s = 1'b1;
                  state_nxt_s   = DONE;
               end
            end else begin
               state_nxt_s = IDLE;
            end
         end
         BUSY: begin
            if (md_done_s) begin
               load_iter_s = 1'b1;
               state_nxt_s = DONE;
            end else begin
               state_nxt_s = BUSY;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = DONE;
            end
         end
         default: state_nxt_s = IDLE;
      endcase
   end

   // State register plus registered handshake outputs derived from the next state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         ready_r     <= 1'b0;
         out_valid_r <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         ready_r     <= (state_nxt_s == IDLE);
         out_valid_r <= (state_nxt_s == DONE);
      end
   end

   // Result and flag registers, captured together when an operation completes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lo_r    <= {WIDTH{1'b0}};
         hi_r    <= {WIDTH{1'b0}};
         carry_r <= 1'b0;
         zero_r  <= 1'b0;
         dbz_r   <= 1'b0;
      end else if (load_single_s) begin
         lo_r    <= sc_lo_s;
         hi_r    <= sc_hi_s;
         carry_r <= sc_carry_s;
         zero_r  <= (sc_lo_s == {WIDTH{1'b0}});
         dbz_r   <= sc_dbz_s;
      end else if (load_iter_s) begin
         lo_r    <= md_lo_s;
         hi_r    <= md_hi_s;
         carry_r <= 1'b0;
         zero_r  <= (md_lo_s == {WIDTH{1'b0}});
         dbz_r   <= 1'b0;
      end
   end

   seq_alu_muldiv #(
      .WIDTH (WIDTH)
   ) u_muldiv (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start_s),
      .is_div (operation == OP_DIV),
      .op_a   (firstInput),
      .op_b   (secondInput),
      .done   (md_done_s),
      .res_lo (md_lo_s),
      .res_hi (md_hi_s)
   );

   assign in_ready  = ready_r;
   assign out_valid = out_valid_r;
   assign ALU_Out   = lo_r;
   assign ALU_OutHi = hi_r;
   assign CarryOut  = carry_r;
   assign ZeroOut   = zero_r;
   assign DivByZero = dbz_r;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu at WIDTH=8: directed table, handshake corner
// cases, and random operations against an arithmetic reference model.
module tb_seq_alu;

   localparam int W = 8;

   typedef struct {
      logic [7:0] lo;
      logic [7:0] hi;
      logic       c;
      logic       z;
      logic       d;
      int         lat;
   } res_t;

   typedef struct {
      logic [3:0] op;
      logic [7:0] a;
      logic [7:0] b;
      res_t       exp;
   } vec_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [3:0]   operation = 4'h0;
   logic [W-1:0] firstInput = 8'h00;
   logic [W-1:0] secondInput = 8'h00;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] ALU_Out;
   logic [W-1:0] ALU_OutHi;
   logic         CarryOut;
   logic         ZeroOut;
   logic         DivByZero;

   int n_vec = 0;
   int n_cmp = 0;
   int n_err = 0;

   vec_t tbl[15];

   seq_alu #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .operation   (operation),
      .firstInput  (firstInput),
      .secondInput (secondInput),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .ALU_Out     (ALU_Out),
      .ALU_OutHi   (ALU_OutHi),
      .CarryOut    (CarryOut),
      .ZeroOut     (ZeroOut),
      .DivByZero   (DivByZero)
   );

   always #5 clk = ~clk;

   // Reference model: plain integer arithmetic on the opcode's meaning.
   function automatic res_t model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
      res_t r;
      int unsigned ia, ib, t;
      ia = a; ib = b;
      r.hi = 8'h00; r.c = 1'b0; r.d = 1'b0; r.lat = 1;
      case (op)
         4'h1: begin t = (ia + 256 - ib) % 256; r.lo = 8'(t); r.c = (ia >= ib); end
         4'h2: begin t = ia * ib; r.lo = 8'(t % 256); r.hi = 8'(t / 256); r.lat = W + 1; end
         4'h3: begin
            if (ib == 0) begin r.lo = 8'hFF; r.hi = a; r.d = 1'b1; end
            else begin r.lo = 8'(ia / ib); r.hi = 8'(ia % ib); r.lat = W + 1; end
         end
         4'h8: r.lo = a & b;
         4'h9: r.lo = a | b;
         4'hA: r.lo = a ^ b;
         default: begin t = ia + ib; r.lo = 8'(t % 256); r.c = (t > 255); end
      endcase
      r.z = (r.lo == 8'h00);
      return r;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic wait_ready(input string tag);
      int guard = 0;
      while (!in_ready && guard < 100) begin @(posedge clk); #1; guard++; end
      check({tag, ":ready_before_issue"}, 64'(in_ready), 64'd1);
   endtask

   // Issue one op, scramble inputs while it is in flight, measure latency, check result.
   task automatic run_vec(input string tag, input logic [3:0] op, input logic [7:0] a,
                          input logic [7:0] b, input res_t exp, input bit rdy_early);
      int  lat;
      bit  leak;
      wait_ready(tag);
      operation = op; firstInput = a; secondInput = b; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      operation = 4'($urandom); firstInput = 8'($urandom); secondInput = 8'($urandom);
      if (rdy_early) out_ready = 1'b1;
      lat = 1; leak = 1'b0;
      while (!out_valid && lat < 40) begin
         if (in_ready) leak = 1'b1;
         @(posedge clk); #1; lat++;
      end
      n_vec++;
      check({tag, ":latency"}, 64'(lat), 64'(exp.lat));
      check({tag, ":ready_low"}, 64'(leak | in_ready), 64'd0);
      check({tag, ":ALU_Out"}, 64'(ALU_Out), 64'(exp.lo));
      check({tag, ":ALU_OutHi"}, 64'(ALU_OutHi), 64'(exp.hi));
      check({tag, ":CarryOut"}, 64'(CarryOut), 64'(exp.c));
      check({tag, ":ZeroOut"}, 64'(ZeroOut), 64'(exp.z));
      check({tag, ":DivByZero"}, 64'(DivByZero), 64'(exp.d));
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({tag, ":valid_dropped"}, 64'(out_valid), 64'd0);
      check({tag, ":ready_after"}, 64'(in_ready), 64'd1);
   endtask

   initial begin
      logic [3:0] rop;
      logic [7:0] ra, rb;
      logic [3:0] codes [8];

      // Expected values written out by hand.
      tbl[0]  = '{4'h0, 8'hF0, 8'h20, '{8'h10, 8'h00, 1'b1, 1'b0, 1'b0, 1}};
      tbl[1]  = '{4'h1, 8'h05, 8'h05, '{8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1}};
      tbl[2]  = '{4'h1, 8'h03, 8'h05, '{8'hFE, 8'h00, 1'b0, 1'b0, 1'b0, 1}};
      tbl[3]  = '{4'h2, 8'hFF, 8'hFF, '{8'h01, 8'hFE, 1'b0, 1'b0, 1'b0, 9}};
      tbl[4]  = '{4'h3, 8'h64, 8'h07, '{8'h0E, 8'h02, 1'b0, 1'b0, 1'b0, 9}};
      tbl[5]  = '{4'h3, 8'h64, 8'h00, '{8'hFF, 8'h64, 1'b0, 1'b0, 1'b1, 1}};
      tbl[6]  = '{4'h7, 8'h01, 8'h02, '{8'h03, 8'h00, 1'b0, 1'b0, 1'b0, 1}};
      tbl[7]  = '{4'h8, 8'hF0, 8'h3C, '{8'h30, 8'h00, 1'b0, 1'b0, 1'b0, 1}};
      tbl[8]  = '{4'h9, 8'hF0, 8'h0C, '{8'hFC, 8'h00, 1'b0, 1'b0, 1'b0, 1}};
      tbl[9]  = '{4'hA, 8'hAA, 8'h0F, '{8'hA5, 8'h00, 1'b0, 1'b0, 1'b0, 1}};
      tbl[10] = '{4'h2, 8'h00, 8'h37, '{8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 9}};
      tbl[11] = '{4'h0, 8'hFF, 8'h01, '{8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1}};
      tbl[12] = '{4'hF, 8'h10, 8'h20, '{8'h30, 8'h00, 1'b0, 1'b0, 1'b0, 1}};
      tbl[13] = '{4'h3, 8'h05, 8'h09, '{8'h00, 8'h05, 1'b0, 1'b1, 1'b0, 9}};
      tbl[14] = '{4'h2, 8'h0F, 8'h11, '{8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 9}};

      // Reset state.
      #12;
      check("reset:in_ready", 64'(in_ready), 64'd0);
      check("reset:out_valid", 64'(out_valid), 64'd0);
      check("reset:outputs", 64'({ALU_Out, ALU_OutHi, CarryOut, ZeroOut, DivByZero}), 64'd0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      check("post_reset:in_ready", 64'(in_ready), 64'd1);

      for (int i = 0; i < 15; i++) begin
         run_vec($sformatf("tbl%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp, 1'b0);
      end

      // Backpressure: XOR result must hold while new operands and in_valid wiggle.
      wait_ready("bp");
      operation = 4'hA; firstInput = 8'hAA; secondInput = 8'h0F; in_valid = 1'b1;
      @(posedge clk); #1;
      check("bp:out_valid", 64'(out_valid), 64'd1);
      for (int k = 0; k < 5; k++) begin
         operation = 4'h0; firstInput = 8'($urandom); secondInput = 8'($urandom); in_valid = 1'b1;
         @(posedge clk); #1;
         n_vec++;
         check("bp:hold_ALU_Out", 64'(ALU_Out), 64'hA5);
         check("bp:hold_valid", 64'(out_valid), 64'd1);
         check("bp:hold_ready", 64'(in_ready), 64'd0);
      end
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("bp:released_ready", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      check("bp:no_phantom_op", 64'(out_valid), 64'd0);

      // Reset in the middle of a multiply: everything clears at once.
      wait_ready("rst");
      operation = 4'h2; firstInput = 8'hFF; secondInput = 8'hFF; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst:busy_no_valid", 64'(out_valid), 64'd0);
      rst_n = 1'b0;
      #1;
      n_vec++;
      check("rst:out_valid", 64'(out_valid), 64'd0);
      check("rst:in_ready", 64'(in_ready), 64'd0);
      check("rst:ALU_Out", 64'(ALU_Out), 64'd0);
      check("rst:outputs", 64'({ALU_OutHi, CarryOut, ZeroOut, DivByZero}), 64'd0);
      repeat (2) @(posedge clk);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      check("rst:ready_after_release", 64'(in_ready), 64'd1);
      run_vec("rst:add_after", 4'h0, 8'h12, 8'h34, model(4'h0, 8'h12, 8'h34), 1'b0);

      // Random operations against the reference model.
      codes = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h8, 4'h9, 4'hA, 4'h0};
      for (int i = 0; i < 150; i++) begin
         rop = codes[$urandom_range(0, 7)];
         if ($urandom_range(0, 7) == 0) rop = 4'($urandom);
         ra = 8'($urandom);
         rb = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
         run_vec($sformatf("rnd%0d_op%0h_%02h_%02h", i, rop, ra, rb), rop, ra, rb,
                 model(rop, ra, rb), 1'($urandom_range(0, 1)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
